// File: rtl/reg_mem.sv
// reg_mem: memory-stage pipeline register and data-memory sequencer.
// Latency: ALU ops reach WB one edge after capture; a memory op stays in M
//   for ack-wait + 2 cycles, or TIMEOUT + 2 cycles when the access times out.
// Backpressure: stallM_o holds upstream stages while an access is outstanding.
//   enbM holds the M register and bubbles WB.
// Ports:
//   clk, rst                      clock, async active-high reset
//   alu_resM..sx_2M_ctrl          instruction fields from the execute stage
//   enbM, flashM                  hold / flush from the hazard unit
//   dmem_req/we/addr/be/wdata     data-memory request (zero while idle)
//   dmem_ack, dmem_rdata          single-cycle completion pulse and read data
//   stallM_o                      stage busy
//   wb_data, wb_rd, wb_we_reg     registered write-back bundle
//   bus_err                       sticky timeout flag
module reg_mem #(
  // Wait budget in BUSY before abandoning an access; legal range is 2..255.
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_resM,
  input  logic [31:0] wdataM,
  input  logic [4:0]  rdM,
  input  logic        we_regM,
  input  logic [3:0]  be_memM,
  input  logic [1:0]  cmdM,
  input  logic [2:0]  sx_2M_ctrl,
  input  logic        enbM,
  input  logic        flashM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stallM_o,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we_reg,
  output logic        bus_err
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // M register
  logic [31:0] r_alu_res;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_we_reg;
  logic [3:0]  r_be;
  logic [1:0]  r_cmd;
  logic [2:0]  r_sx;

  // Sequencer state
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_ld_q;
  logic        r_bus_err;

  // WB register
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;

  logic        w_mem_op;
  logic        w_stall;
  logic        w_req;
  logic        w_flush;
  logic        w_capture;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ld_ext;

  assign w_mem_op  = (r_cmd == 2'b01) || (r_cmd == 2'b10);
  assign w_stall   = w_mem_op && (r_state != S_DONE);
  // Request is decoded from registers only, so an async reset drops it at once.
  assign w_req     = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_mem_op);
  // A started bus access cannot be cancelled, so flush is ignored in BUSY.
  assign w_flush   = flashM && (r_state != S_BUSY);
  assign w_capture = !enbM && !w_stall;

  // M register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_res <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_we_reg  <= 1'b0;
      r_be      <= '0;
      r_cmd     <= '0;
      r_sx      <= '0;
    end else if (w_flush) begin
      r_alu_res <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_we_reg  <= 1'b0;
      r_be      <= '0;
      r_cmd     <= '0;
      r_sx      <= '0;
    end else if (w_capture) begin
      r_alu_res <= alu_resM;
      r_wdata   <= wdataM;
      r_rd      <= rdM;
      r_we_reg  <= we_regM;
      r_be      <= be_memM;
      r_cmd     <= cmdM;
      r_sx      <= sx_2M_ctrl;
    end
  end

  // Access sequencer. DONE parks the FSM until M takes a new instruction,
  // which keeps a completed access from being requested a second time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ld_q    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            if (dmem_ack) begin
              r_state <= S_DONE;
              r_ld_q  <= dmem_rdata;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= 8'd1;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_state <= S_DONE;
            r_ld_q  <= dmem_rdata;
            r_cnt   <= '0;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_state   <= S_DONE;
            r_ld_q    <= '0;
            r_bus_err <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (w_flush || w_capture) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Load extraction from the captured word, lane picked by the address.
  always_comb begin
    w_half = r_alu_res[1] ? r_ld_q[31:16] : r_ld_q[15:0];
    case (r_alu_res[1:0])
      2'd0:    w_byte = r_ld_q[7:0];
      2'd1:    w_byte = r_ld_q[15:8];
      2'd2:    w_byte = r_ld_q[23:16];
      default: w_byte = r_ld_q[31:24];
    endcase
    case (r_sx)
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ld_ext = {16'd0, w_half};
      3'b011:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {24'd0, w_byte};
      default: w_ld_ext = r_ld_q;
    endcase
  end

  // WB register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
    end else if (w_stall || enbM) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
    end else begin
      r_wb_data <= (r_cmd == 2'b01) ? w_ld_ext : r_alu_res;
      r_wb_rd   <= r_rd;
      r_wb_we   <= r_we_reg;
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req && (r_cmd == 2'b10);
  assign dmem_addr  = w_req ? r_alu_res : '0;
  assign dmem_be    = w_req ? r_be      : '0;
  assign dmem_wdata = w_req ? r_wdata   : '0;
  assign stallM_o   = w_stall;
  assign wb_data    = r_wb_data;
  assign wb_rd      = r_wb_rd;
  assign wb_we_reg  = r_wb_we;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_reg_mem.sv
// tb_reg_mem: directed bench for reg_mem with TIMEOUT = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_reg_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_resM;
  logic [31:0] wdataM;
  logic [4:0]  rdM;
  logic        we_regM;
  logic [3:0]  be_memM;
  logic [1:0]  cmdM;
  logic [2:0]  sx_2M_ctrl;
  logic        enbM;
  logic        flashM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stallM_o;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we_reg;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_mem #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_resM   (alu_resM),
    .wdataM     (wdataM),
    .rdM        (rdM),
    .we_regM    (we_regM),
    .be_memM    (be_memM),
    .cmdM       (cmdM),
    .sx_2M_ctrl (sx_2M_ctrl),
    .enbM       (enbM),
    .flashM     (flashM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .stallM_o   (stallM_o),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we_reg  (wb_we_reg),
    .bus_err    (bus_err)
  );

  // Zero-wait load vectors: format, address, read word, expected WB data.
  logic [2:0]  lt_sx    [8] = '{3'b011, 3'b100, 3'b001, 3'b000,
                                3'b111, 3'b001, 3'b011, 3'b100};
  logic [31:0] lt_addr  [8] = '{32'h1002, 32'h1001, 32'h1000, 32'h1000,
                                32'h1003, 32'h1002, 32'h1003, 32'h1000};
  logic [31:0] lt_rdata [8] = '{32'h0080FF00, 32'h0080FF00, 32'h12348765, 32'hCAFEF00D,
                                32'h0BADBEEF, 32'h7FFF0001, 32'h7F000000, 32'h000000C3};
  logic [31:0] lt_exp   [8] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF8765, 32'hCAFEF00D,
                                32'h0BADBEEF, 32'h00007FFF, 32'h0000007F, 32'h000000C3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    cmdM       = 2'b00;
    alu_resM   = '0;
    wdataM     = '0;
    rdM        = '0;
    we_regM    = 1'b0;
    be_memM    = '0;
    sx_2M_ctrl = '0;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic we, input logic [3:0] be,
                       input logic [2:0] sx);
    cmdM       = cmd;
    alu_resM   = addr;
    wdataM     = wd;
    rdM        = rd;
    we_regM    = we;
    be_memM    = be;
    sx_2M_ctrl = sx;
  endtask

  // Present one instruction for a single capture edge, then fall back to nops.
  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic we, input logic [3:0] be,
                       input logic [2:0] sx);
    drive(cmd, addr, wd, rd, we, be, sx);
    tick();
    set_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int stable;
    int n_req;

    // Reset with arbitrary live inputs
    drive(2'b01, 32'hFFFFFFFF, 32'hA5A5A5A5, 5'd31, 1'b1, 4'hF, 3'b011);
    enbM       = 1'b0;
    flashM     = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    repeat (3) tick();
    check("rst_req",    dmem_req,   32'd0);
    check("rst_we",     dmem_we,    32'd0);
    check("rst_addr",   dmem_addr,  32'd0);
    check("rst_be",     dmem_be,    32'd0);
    check("rst_wdata",  dmem_wdata, 32'd0);
    check("rst_stall",  stallM_o,   32'd0);
    check("rst_wbdata", wb_data,    32'd0);
    check("rst_wbrd",   wb_rd,      32'd0);
    check("rst_wbwe",   wb_we_reg,  32'd0);
    check("rst_buserr", bus_err,    32'd0);
    set_nop();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    rst        = 1'b0;
    tick();

    // Zero-wait loads: one stall cycle, WB valid two edges after capture
    for (int i = 0; i < 8; i++) begin
      issue(2'b01, lt_addr[i], 32'h0, 5'(i + 1), 1'b1, 4'hF, lt_sx[i]);
      check($sformatf("zw%0d_req", i),   dmem_req,  32'd1);
      check($sformatf("zw%0d_stall", i), stallM_o,  32'd1);
      check($sformatf("zw%0d_addr", i),  dmem_addr, lt_addr[i]);
      dmem_ack   = 1'b1;
      dmem_rdata = lt_rdata[i];
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hFFFFFFFF;
      check($sformatf("zw%0d_stall_done", i), stallM_o,  32'd0);
      check($sformatf("zw%0d_req_done", i),   dmem_req,  32'd0);
      check($sformatf("zw%0d_wb_bubble", i),  wb_we_reg, 32'd0);
      tick();
      check($sformatf("zw%0d_wbdata", i), wb_data,   lt_exp[i]);
      check($sformatf("zw%0d_wbrd", i),   wb_rd,     32'(i + 1));
      check($sformatf("zw%0d_wbwe", i),   wb_we_reg, 32'd1);
    end

    // Store with the ack three cycles after the request opens
    issue(2'b10, 32'h2000, 32'hDEADBEEF, 5'd0, 1'b0, 4'hF, 3'd0);
    stable = 0;
    for (int i = 0; i < 4; i++) begin
      if (dmem_req && dmem_we && dmem_addr == 32'h2000 && dmem_wdata == 32'hDEADBEEF &&
          dmem_be == 4'hF && stallM_o && !wb_we_reg)
        stable++;
      if (i == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check("st_stable_cycles", 32'(stable), 32'd4);
    check("st_req_after",     dmem_req,    32'd0);
    check("st_we_after",      dmem_we,     32'd0);
    check("st_stall_after",   stallM_o,    32'd0);
    tick();
    check("st_wb_we",         wb_we_reg,   32'd0);
    check("st_no_rereq",      dmem_req,    32'd0);

    // Timeout on an LW with garbage on the read bus and no ack
    dmem_rdata = 32'h12345678;
    issue(2'b01, 32'h4000, 32'h0, 5'd7, 1'b1, 4'hF, 3'b000);
    check("to_err_before", bus_err, 32'd0);
    n_req = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      n_req++;
      tick();
    end
    check("to_req_cycles", 32'(n_req), 32'd5);
    check("to_err_set",    bus_err,    32'd1);
    check("to_stall_off",  stallM_o,   32'd0);
    tick();
    check("to_wbdata",     wb_data,    32'd0);
    check("to_wbwe",       wb_we_reg,  32'd1);
    check("to_wbrd",       wb_rd,      32'd7);
    issue(2'b00, 32'h55, 32'h0, 5'd3, 1'b1, 4'h0, 3'd0);
    tick();
    check("to_next_data",  wb_data,    32'h55);
    check("to_next_rd",    wb_rd,      32'd3);
    check("to_next_we",    wb_we_reg,  32'd1);
    check("to_err_sticky", bus_err,    32'd1);
    dmem_rdata = '0;

    // Flush in IDLE replaces the M contents with a bubble
    drive(2'b00, 32'h11, 32'h0, 5'd4, 1'b1, 4'h0, 3'd0);
    tick();
    drive(2'b00, 32'h22, 32'h0, 5'd6, 1'b1, 4'h0, 3'd0);
    flashM = 1'b1;
    tick();
    flashM = 1'b0;
    set_nop();
    check("fl_prev_data", wb_data,   32'h11);
    check("fl_prev_we",   wb_we_reg, 32'd1);
    tick();
    check("fl_bubble_we", wb_we_reg, 32'd0);
    check("fl_bubble_rd", wb_rd,     32'd0);

    // Flush during BUSY is ignored; LHU of the upper half
    issue(2'b01, 32'h3002, 32'h0, 5'd9, 1'b1, 4'hC, 3'b010);
    tick();
    flashM = 1'b1;
    check("flb_req",   dmem_req,  32'd1);
    tick();
    check("flb_req_held",  dmem_req,  32'd1);
    check("flb_addr_held", dmem_addr, 32'h3002);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80010000;
    tick();
    flashM     = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    tick();
    check("flb_wbdata", wb_data,   32'h00008001);
    check("flb_wbrd",   wb_rd,     32'd9);
    check("flb_wbwe",   wb_we_reg, 32'd1);

    // Hold for three cycles after a completed LBU
    issue(2'b01, 32'h5001, 32'h0, 5'd10, 1'b1, 4'hF, 3'b100);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hA5C3E7F1;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    enbM       = 1'b1;
    check("hold_req0", dmem_req, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d_req", i),  dmem_req,  32'd0);
      check($sformatf("hold%0d_wbwe", i), wb_we_reg, 32'd0);
    end
    enbM = 1'b0;
    tick();
    check("hold_rel_data", wb_data,   32'h000000E7);
    check("hold_rel_rd",   wb_rd,     32'd10);
    check("hold_rel_we",   wb_we_reg, 32'd1);
    tick();
    check("hold_once",     wb_we_reg, 32'd0);

    // Ack with no request outstanding has no effect
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_ack   = 1'b0;
    check("stray_ack_req",   dmem_req, 32'd0);
    check("stray_ack_stall", stallM_o, 32'd0);

    // Asynchronous reset while BUSY drops the request immediately
    issue(2'b01, 32'h6000, 32'h0, 5'd11, 1'b1, 4'hF, 3'b000);
    tick();
    check("rb_busy_req", dmem_req, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rb_req_drop",   dmem_req,  32'd0);
    check("rb_addr_drop",  dmem_addr, 32'd0);
    check("rb_stall_drop", stallM_o,  32'd0);
    check("rb_buserr_clr", bus_err,   32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rb_after_req",  dmem_req,  32'd0);
    check("rb_after_wbwe", wb_we_reg, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
